// File: rtl/mouse_packet_arbiter_pkg.sv
// ============================================================================
// Module   : mouse_packet_arbiter_pkg
// Brief    : Shared packet field layout, FSM states and delta helpers for the
//            two-source ps2_mouse packet arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mouse_packet_arbiter_pkg;

  localparam int PKT_W      = 25;
  localparam int STROBE_BIT = 24;
  localparam int Y_LO_MSB   = 23;
  localparam int Y_LO_LSB   = 16;
  localparam int X_LO_MSB   = 15;
  localparam int X_LO_LSB   = 8;
  localparam int PAD_MSB    = 7;
  localparam int PAD_LSB    = 6;
  localparam int Y_SIGN_BIT = 5;
  localparam int X_SIGN_BIT = 4;
  localparam int MARKER_BIT = 3;
  localparam int BTN_MSB    = 2;
  localparam int BTN_W      = 3;
  localparam int GAP_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  typedef logic signed [8:0] delta_t;

  localparam delta_t DELTA_MAX = 9'sh0FF;
  localparam delta_t DELTA_MIN = 9'sh100;

  // Sign-extend to 10 bits so the true sum is visible before clamping.
  function automatic delta_t sat_add(input delta_t a, input delta_t b);
    logic signed [9:0] sum;
    sum = $signed({a[8], a}) + $signed({b[8], b});
    if (sum > 10'sd255) begin
      return DELTA_MAX;
    end else if (sum < -10'sd256) begin
      return DELTA_MIN;
    end else begin
      return delta_t'(sum[8:0]);
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/mouse_packet_slot.sv
// ============================================================================
// Module   : mouse_packet_slot
// Brief    : One source's strobe detector and pending-packet slot. Build
//            option MOUSE_ARB_MERGE_EN coalesces repeat packets by saturating
//            add; otherwise a repeat overwrites and flags overrun.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mouse_packet_slot
  import mouse_packet_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [PKT_W-1:0] pkt,
  input  logic             clr,
  output logic             valid,
  output delta_t           dx,
  output delta_t           dy,
  output logic [BTN_W-1:0] btn,
  output logic             overrun
);

  logic             strobe_q, strobe_d;
  logic             arm_q, arm_d;
  logic             valid_q, valid_d;
  delta_t           dx_q, dx_d;
  delta_t           dy_q, dy_d;
  logic [BTN_W-1:0] btn_q, btn_d;
  logic             overrun_q, overrun_d;

  logic             new_pkt;
  delta_t           in_dx;
  delta_t           in_dy;
  logic [BTN_W-1:0] in_btn;
  logic             unused_pkt_bits;

  assign unused_pkt_bits = ^{pkt[PAD_MSB:PAD_LSB], pkt[MARKER_BIT]};

  always_comb begin
    new_pkt   = arm_q && (pkt[STROBE_BIT] != strobe_q);
    in_dx     = delta_t'({pkt[X_SIGN_BIT], pkt[X_LO_MSB:X_LO_LSB]});
    in_dy     = delta_t'({pkt[Y_SIGN_BIT], pkt[Y_LO_MSB:Y_LO_LSB]});
    in_btn    = pkt[BTN_MSB:0];

    strobe_d  = pkt[STROBE_BIT];
    arm_d     = 1'b1;
    valid_d   = valid_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    btn_d     = btn_q;
    overrun_d = overrun_q;

    if (!en) begin
      valid_d = 1'b0;
      dx_d    = '0;
      dy_d    = '0;
      btn_d   = '0;
    end else if (new_pkt) begin
      valid_d = 1'b1;
      btn_d   = in_btn;
      // A slot being emitted this cycle starts fresh rather than coalescing.
      if (valid_q && !clr) begin
`ifdef MOUSE_ARB_MERGE_EN
        dx_d = sat_add(dx_q, in_dx);
        dy_d = sat_add(dy_q, in_dy);
`else
        dx_d      = in_dx;
        dy_d      = in_dy;
        overrun_d = 1'b1;
`endif
      end else begin
        dx_d = in_dx;
        dy_d = in_dy;
      end
    end else if (clr) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_q  <= 1'b0;
      arm_q     <= 1'b0;
      valid_q   <= 1'b0;
      dx_q      <= '0;
      dy_q      <= '0;
      btn_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      strobe_q  <= strobe_d;
      arm_q     <= arm_d;
      valid_q   <= valid_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      btn_q     <= btn_d;
      overrun_q <= overrun_d;
    end
  end

  assign valid   = valid_q;
  assign dx      = dx_q;
  assign dy      = dy_q;
  assign btn     = btn_q;
  assign overrun = overrun_q;

endmodule

`default_nettype wire

// File: rtl/mouse_packet_arbiter.sv
// ============================================================================
// Module   : mouse_packet_arbiter
// Brief    : Round-robin arbiter sharing one ps2_mouse-format packet stream
//            between two sources with a minimum gap between output toggles.
//            Build option MOUSE_ARB_MERGE_EN selects coalescing slots.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mouse_packet_arbiter
  import mouse_packet_arbiter_pkg::*;
#(
  parameter int MIN_GAP = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       src_en,
  input  logic [PKT_W-1:0] mouse_a,
  input  logic [PKT_W-1:0] mouse_b,
  output logic [PKT_W-1:0] mouse_out,
  output logic             grant_src,
  output logic [1:0]       overrun
);

  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 1);

  logic [PKT_W-1:0] src_pkt [2];
  logic [1:0]       slot_valid;
  logic [1:0]       slot_clr;
  delta_t           slot_dx [2];
  delta_t           slot_dy [2];
  logic [BTN_W-1:0] slot_btn [2];

  assign src_pkt[0] = mouse_a;
  assign src_pkt[1] = mouse_b;

  for (genvar i = 0; i < 2; i++) begin : g_slot
    mouse_packet_slot u_slot (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (src_en[i]),
      .pkt     (src_pkt[i]),
      .clr     (slot_clr[i]),
      .valid   (slot_valid[i]),
      .dx      (slot_dx[i]),
      .dy      (slot_dy[i]),
      .btn     (slot_btn[i]),
      .overrun (overrun[i])
    );
  end

  arb_state_e       state_q, state_d;
  logic             sel_q, sel_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [PKT_W-1:0] mouse_out_q, mouse_out_d;
  logic             grant_src_q, grant_src_d;

  delta_t           sel_dx;
  delta_t           sel_dy;
  logic [BTN_W-1:0] sel_btn;

  always_comb begin
    sel_dx      = sel_q ? slot_dx[1]  : slot_dx[0];
    sel_dy      = sel_q ? slot_dy[1]  : slot_dy[0];
    sel_btn     = sel_q ? slot_btn[1] : slot_btn[0];

    state_d     = state_q;
    sel_d       = sel_q;
    gap_cnt_d   = gap_cnt_q;
    mouse_out_d = mouse_out_q;
    grant_src_d = grant_src_q;
    slot_clr    = '0;

    case (state_q)
      ST_IDLE: begin
        if (|slot_valid) begin
          state_d = ST_EMIT;
          sel_d   = (&slot_valid) ? ~grant_src_q : slot_valid[1];
        end
      end

      ST_EMIT: begin
        slot_clr[sel_q] = 1'b1;
        // A slot disabled between grant and emit has nothing left to send.
        if (slot_valid[sel_q]) begin
          mouse_out_d                     = '0;
          mouse_out_d[STROBE_BIT]         = ~mouse_out_q[STROBE_BIT];
          mouse_out_d[Y_LO_MSB:Y_LO_LSB]  = sel_dy[7:0];
          mouse_out_d[X_LO_MSB:X_LO_LSB]  = sel_dx[7:0];
          mouse_out_d[Y_SIGN_BIT]         = sel_dy[8];
          mouse_out_d[X_SIGN_BIT]         = sel_dx[8];
          mouse_out_d[MARKER_BIT]         = 1'b1;
          mouse_out_d[BTN_MSB:0]          = sel_btn;
          grant_src_d                     = sel_q;
          gap_cnt_d                       = GAP_LOAD;
          state_d                         = ST_GAP;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_GAP: begin
        if (gap_cnt_q <= GAP_W'(1)) begin
          gap_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= 1'b0;
      gap_cnt_q   <= '0;
      mouse_out_q <= '0;
      grant_src_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      gap_cnt_q   <= gap_cnt_d;
      mouse_out_q <= mouse_out_d;
      grant_src_q <= grant_src_d;
    end
  end

  assign mouse_out = mouse_out_q;
  assign grant_src = grant_src_q;

endmodule

`default_nettype wire

// File: tb/tb_mouse_packet_arbiter.sv
// ============================================================================
// Module   : tb_mouse_packet_arbiter
// Brief    : Scoreboard bench for mouse_packet_arbiter (either build of
//            MOUSE_ARB_MERGE_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mouse_packet_arbiter;

  localparam int MIN_GAP = 16;
  localparam int LAT     = 3;
  localparam int SPACING = MIN_GAP + 1;
  localparam int SETTLE  = 45;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  src_en;
  logic [24:0] mouse_a;
  logic [24:0] mouse_b;
  logic [24:0] mouse_out;
  logic        grant_src;
  logic [1:0]  overrun;

  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mouse_packet_arbiter #(.MIN_GAP(MIN_GAP)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .src_en    (src_en),
    .mouse_a   (mouse_a),
    .mouse_b   (mouse_b),
    .mouse_out (mouse_out),
    .grant_src (grant_src),
    .overrun   (overrun)
  );

  typedef struct {
    logic [23:0] body;
    logic        gsrc;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  logic exp_tog;
  logic tog_a;
  logic tog_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [24:0] mk_in(input logic t, input logic [8:0] x,
                                        input logic [8:0] y, input logic [2:0] b);
    return {t, y[7:0], x[7:0], 2'b00, y[8], x[8], 1'b0, b};
  endfunction

  task automatic send_a(input logic [8:0] x, input logic [8:0] y, input logic [2:0] b);
    tog_a   = ~tog_a;
    mouse_a = mk_in(tog_a, x, y, b);
  endtask

  task automatic send_b(input logic [8:0] x, input logic [8:0] y, input logic [2:0] b);
    tog_b   = ~tog_b;
    mouse_b = mk_in(tog_b, x, y, b);
  endtask

  task automatic expect_pkt(input logic [23:0] body, input logic g, input int at);
    exp_t e;
    e.body = body;
    e.gsrc = g;
    e.at   = at;
    sb.push_back(e);
  endtask

  task automatic monitor();
    logic [24:0] last;
    exp_t        e;
    last = mouse_out;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        last = mouse_out;
      end else if (mouse_out !== last) begin
        if (sb.size() == 0) begin
          check("unexpected_pkt", mouse_out, last);
        end else begin
          e       = sb.pop_front();
          exp_tog = ~exp_tog;
          check("pkt_data", mouse_out, {exp_tog, e.body});
          check("pkt_grant", grant_src, e.gsrc);
          check("pkt_cycle", cyc, e.at);
        end
        last = mouse_out;
      end else if (sb.size() != 0 && cyc > sb[0].at) begin
        e       = sb.pop_front();
        exp_tog = ~exp_tog;
        check("pkt_timeout_cycle", cyc, e.at);
      end
    end
  endtask

  int          k;
  logic [24:0] snap;
  logic [1:0]  exp_ovr;

  initial begin
`ifdef MOUSE_ARB_MERGE_EN
    exp_ovr = 2'b00;
`else
    exp_ovr = 2'b01;
`endif
    reset_n = 1'b0;
    src_en  = 2'b11;
    tog_a   = 1'b1;
    tog_b   = 1'b0;
    mouse_a = 25'h1000000;
    mouse_b = '0;
    exp_tog = 1'b0;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check("reset_mouse_out", mouse_out, 25'h0);
    check("reset_grant_src", grant_src, 1'b1);
    check("reset_overrun", overrun, 2'b00);

    // bit24 held high across release must not produce a packet.
    reset_n = 1'b1;
    repeat (25) @(negedge clk);
    check("no_pkt_after_reset", mouse_out, 25'h0);

    // Tie after reset: A first, B one gap later; repeated tie goes to A again.
    k = cyc;
    send_a(9'sd1, 9'sd2, 3'b000);
    send_b(-9'sd1, 9'sd0, 3'b111);
    expect_pkt(24'h020108, 1'b0, k + LAT);
    expect_pkt(24'h00FF1F, 1'b1, k + LAT + SPACING);
    repeat (SETTLE) @(negedge clk);

    k = cyc;
    send_a(9'sd127, -9'sd128, 3'b010);
    send_b(9'sd255, 9'sd255, 3'b100);
    expect_pkt(24'h807F2A, 1'b0, k + LAT);
    expect_pkt(24'hFFFF0C, 1'b1, k + LAT + SPACING);
    repeat (SETTLE) @(negedge clk);

    // Single packet X=+5 Y=-3.
    k = cyc;
    send_a(9'sd5, -9'sd3, 3'b001);
    expect_pkt(24'hFD0529, 1'b0, k + LAT);
    repeat (SETTLE) @(negedge clk);

    // Two A packets land while B's packet holds the gap.
    k = cyc;
    send_b(9'sd0, 9'sd0, 3'b000);
    expect_pkt(24'h000008, 1'b1, k + LAT);
    repeat (5) @(negedge clk);
    send_a(9'sd200, 9'sd0, 3'b000);
    repeat (2) @(negedge clk);
    send_a(9'sd100, 9'sd0, 3'b000);
`ifdef MOUSE_ARB_MERGE_EN
    expect_pkt(24'h00FF08, 1'b0, k + LAT + SPACING);
`else
    expect_pkt(24'h006408, 1'b0, k + LAT + SPACING);
`endif
    repeat (SETTLE) @(negedge clk);
    check("overrun_after_pos", overrun, exp_ovr);

    k = cyc;
    send_b(9'sd0, 9'sd0, 3'b101);
    expect_pkt(24'h00000D, 1'b1, k + LAT);
    repeat (5) @(negedge clk);
    send_a(-9'sd200, 9'sd0, 3'b000);
    repeat (2) @(negedge clk);
    send_a(-9'sd100, 9'sd0, 3'b000);
`ifdef MOUSE_ARB_MERGE_EN
    expect_pkt(24'h000018, 1'b0, k + LAT + SPACING);
`else
    expect_pkt(24'h009C18, 1'b0, k + LAT + SPACING);
`endif
    repeat (SETTLE) @(negedge clk);

    // Disabled source is ignored; re-enabling does not replay it.
    snap   = mouse_out;
    src_en = 2'b10;
    send_a(9'sd1, 9'sd1, 3'b000);
    repeat (30) @(negedge clk);
    check("disabled_no_pkt", mouse_out, snap);
    src_en = 2'b11;
    repeat (30) @(negedge clk);
    check("reenabled_no_pkt", mouse_out, snap);
    k = cyc;
    send_a(9'sd3, 9'sd0, 3'b000);
    expect_pkt(24'h000308, 1'b0, k + LAT);
    repeat (SETTLE) @(negedge clk);
    check("overrun_sticky", overrun, exp_ovr);

    // Reset during GAP with A pending.
    k = cyc;
    send_b(9'sd2, 9'sd2, 3'b000);
    expect_pkt(24'h020208, 1'b1, k + LAT);
    repeat (5) @(negedge clk);
    send_a(9'sd4, 9'sd4, 3'b000);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset_mouse_out", mouse_out, 25'h0);
    check("midreset_grant_src", grant_src, 1'b1);
    check("midreset_overrun", overrun, 2'b00);
    sb.delete();
    exp_tog = 1'b0;
    tog_a   = 1'b1;
    mouse_a = mk_in(1'b1, 9'sd4, 9'sd4, 3'b000);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    check("no_pkt_after_midreset", mouse_out, 25'h0);

    k = cyc;
    send_a(9'sd7, 9'sd0, 3'b000);
    expect_pkt(24'h000708, 1'b0, k + LAT);
    repeat (30) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
